// File: rtl/ctx_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctx_loader_pkg
// Description : Shared definitions for the context loader and the PE context
//               caches. Holds the default geometry (word width, PE count,
//               slots per PE), the slot-counter width and the loader FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ctx_loader_pkg;

    localparam int unsigned c_def_width  = 120;  // context word is WIDTH+1 bits
    localparam int unsigned c_def_num_pe = 16;
    localparam int unsigned c_def_depth  = 16;
    localparam int unsigned c_pe_idx_w   = 4;    // width of PE index and slot address
    localparam int unsigned c_cnt_w      = 5;    // slot counter must be able to hold DEPTH

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_RUN  = 2'd3
    } ctx_state_t;

endpackage
`default_nettype wire

// File: rtl/ctx_slot_ctr.sv
`default_nettype none
// ============================================================================
// Module      : ctx_slot_ctr
// Description : Bank of per-PE saturating slot counters.
//               clk, rst_n : clock, asynchronous active-low reset
//               clr        : zero every counter
//               inc        : increment the counter selected by idx
//               idx        : PE index used for both increment and read-out
//               slot       : next free slot of the PE selected by idx
//               full       : the selected PE has all DEPTH slots written
// Revision    : 1.0 - initial release
// ============================================================================
module ctx_slot_ctr
    import ctx_loader_pkg::*;
#(
    parameter int unsigned NUM_PE = c_def_num_pe,
    parameter int unsigned DEPTH  = c_def_depth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    input  logic [c_pe_idx_w-1:0] idx,
    output logic [c_pe_idx_w-1:0] slot,
    output logic                  full
);

    localparam logic [c_cnt_w-1:0] c_full_val = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    logic [NUM_PE-1:0][c_cnt_w-1:0] w_cnt;
    logic [c_cnt_w-1:0]             w_sel;

    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_ctr
            localparam logic [c_pe_idx_w-1:0] c_idx = c_pe_idx_w'(gi);
            logic [c_cnt_w-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (clr) begin
                    r_cnt <= '0;
                end else if (inc && (idx == c_idx) && (r_cnt != c_full_val)) begin
                    r_cnt <= r_cnt + c_one;
                end
            end

            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    // Indices with no counter behind them read as an empty, non-full PE;
    // the loader rejects those indices on its own.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < int'(NUM_PE); i++) begin
            if (idx == c_pe_idx_w'(i)) begin
                w_sel = w_cnt[i];
            end
        end
    end

    assign full = (w_sel == c_full_val);
    assign slot = w_sel[c_pe_idx_w-1:0];

endmodule
`default_nettype wire

// File: rtl/ctx_loader.sv
`default_nettype none
// ============================================================================
// Module      : ctx_loader
// Description : Streams host context words into per-PE context caches, then
//               sequences execution of the PE array.
//               s_valid/s_ready/s_data/s_pe/s_last : host word stream
//               go / halt : start execution after load / return to idle
//               pe_data/pe_we/pe_addr : registered cache write port
//                 (data broadcast, one-hot per-PE strobe, slot address)
//               start : level, high while the PEs execute
//               busy  : loading or loaded-awaiting-go
//               err   : sticky slot-overflow / bad-PE-index flag
// Revision    : 1.0 - initial release
// ============================================================================
module ctx_loader
    import ctx_loader_pkg::*;
#(
    parameter int unsigned WIDTH  = c_def_width,
    parameter int unsigned NUM_PE = c_def_num_pe,
    parameter int unsigned DEPTH  = c_def_depth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH:0]        s_data,
    input  logic [c_pe_idx_w-1:0] s_pe,
    input  logic                  s_last,
    input  logic                  go,
    input  logic                  halt,
    output logic [WIDTH:0]        pe_data,
    output logic [NUM_PE-1:0]     pe_we,
    output logic [c_pe_idx_w-1:0] pe_addr,
    output logic                  start,
    output logic                  busy,
    output logic                  err
);

    ctx_state_t              r_state;
    ctx_state_t              w_next;
    logic                    w_xfer;
    logic                    w_bad_idx;
    logic                    w_write;
    logic                    w_clr;
    logic                    w_full;
    logic [c_pe_idx_w-1:0]   w_slot;
    logic [NUM_PE-1:0]       w_onehot;

    // s_ready is a registered copy of "state is LOAD", so it doubles as
    // the LOAD qualifier for the handshake.
    assign w_xfer    = s_valid && s_ready;
    assign w_bad_idx = (32'(s_pe) >= NUM_PE);
    assign w_write   = w_xfer && !w_bad_idx && !w_full;
    // The word that wakes the loader from IDLE only opens a new load.
    assign w_clr     = (r_state == ST_IDLE) && s_valid;

    ctx_slot_ctr #(
        .NUM_PE (NUM_PE),
        .DEPTH  (DEPTH)
    ) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .inc   (w_write),
        .idx   (s_pe),
        .slot  (w_slot),
        .full  (w_full)
    );

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < int'(NUM_PE); i++) begin
            w_onehot[i] = (s_pe == c_pe_idx_w'(i));
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (s_valid)           w_next = ST_LOAD;
            ST_LOAD: if (w_xfer && s_last)  w_next = ST_DONE;
            ST_DONE: if (go)                w_next = ST_RUN;   // go outranks halt here
            ST_RUN:  if (halt)              w_next = ST_IDLE;
            default:                        w_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they always
    // line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            start   <= 1'b0;
            err     <= 1'b0;
            pe_we   <= '0;
            pe_data <= '0;
            pe_addr <= '0;
        end else begin
            r_state <= w_next;
            s_ready <= (w_next == ST_LOAD);
            busy    <= (w_next == ST_LOAD) || (w_next == ST_DONE);
            start   <= (w_next == ST_RUN);
            pe_we   <= w_write ? w_onehot : '0;
            if (w_write) begin
                pe_data <= s_data;
                pe_addr <= w_slot;
            end
            if (w_clr) begin
                err <= 1'b0;
            end else if (w_xfer && !w_write) begin
                err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctx_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctx_loader
// Description : Self-checking bench for ctx_loader. Two instances share one
//               stimulus stream: a 16-PE and an 8-PE configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctx_loader;

    localparam int W      = 120;
    localparam int DEPTHM = 16;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_DONE = 2, PH_RUN = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         s_valid = 1'b0, s_last = 1'b0, go = 1'b0, halt = 1'b0;
    logic [W:0]   s_data = '0;
    logic [3:0]   s_pe = '0;

    logic         a_ready, a_start, a_busy, a_err;
    logic [W:0]   a_data;
    logic [15:0]  a_we;
    logic [3:0]   a_addr;
    logic         b_ready, b_start, b_busy, b_err;
    logic [W:0]   b_data;
    logic [7:0]   b_we;
    logic [3:0]   b_addr;

    ctx_loader #(.WIDTH(W), .NUM_PE(16), .DEPTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(a_ready),
        .s_data(s_data), .s_pe(s_pe), .s_last(s_last), .go(go), .halt(halt),
        .pe_data(a_data), .pe_we(a_we), .pe_addr(a_addr),
        .start(a_start), .busy(a_busy), .err(a_err)
    );

    ctx_loader #(.WIDTH(W), .NUM_PE(8), .DEPTH(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_ready),
        .s_data(s_data), .s_pe(s_pe), .s_last(s_last), .go(go), .halt(halt),
        .pe_data(b_data), .pe_we(b_we), .pe_addr(b_addr),
        .start(b_start), .busy(b_busy), .err(b_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_ph;
    int          m_cnt [2][16];
    int          m_np  [2] = '{16, 8};
    logic [15:0] e_we  [2];
    logic [3:0]  e_addr[2];
    logic [W:0]  e_data[2];
    logic        e_err [2];
    logic        e_ready, e_busy, e_start;
    int          n_tests = 0, n_fail = 0;

    task automatic model_reset();
        m_ph = PH_IDLE;
        for (int k = 0; k < 2; k++) begin
            e_we[k] = '0; e_addr[k] = '0; e_data[k] = '0; e_err[k] = 1'b0;
            for (int p = 0; p < 16; p++) m_cnt[k][p] = 0;
        end
        e_ready = 1'b0; e_busy = 1'b0; e_start = 1'b0;
    endtask

    // Expected outputs after the coming rising edge, from the current inputs.
    task automatic model_edge();
        int pe;
        int nph;
        pe  = int'(s_pe);
        nph = m_ph;
        for (int k = 0; k < 2; k++) e_we[k] = '0;
        case (m_ph)
            PH_IDLE: if (s_valid) begin
                nph = PH_LOAD;
                for (int k = 0; k < 2; k++) begin
                    e_err[k] = 1'b0;
                    for (int p = 0; p < 16; p++) m_cnt[k][p] = 0;
                end
            end
            PH_LOAD: if (s_valid) begin
                for (int k = 0; k < 2; k++) begin
                    if (pe < m_np[k] && m_cnt[k][pe] < DEPTHM) begin
                        e_we[k]   = 16'(1) << pe;
                        e_addr[k] = 4'(m_cnt[k][pe]);
                        e_data[k] = s_data;
                        m_cnt[k][pe]++;
                    end else begin
                        e_err[k] = 1'b1;
                    end
                end
                if (s_last) nph = PH_DONE;
            end
            PH_DONE: if (go) nph = PH_RUN;
            default: if (halt) nph = PH_IDLE;
        endcase
        m_ph    = nph;
        e_ready = (nph == PH_LOAD);
        e_busy  = (nph == PH_LOAD) || (nph == PH_DONE);
        e_start = (nph == PH_RUN);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] rnd_word();
        return (W+1)'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({a_ready, a_busy, a_start, a_err, a_we, a_addr, a_data} !== '0) begin
            n_fail++; $display("FAIL reset16: got %h want 0", {a_ready, a_busy, a_start, a_err, a_we, a_addr, a_data});
        end
        n_tests++;
        if ({b_ready, b_busy, b_start, b_err, b_we, b_addr, b_data} !== '0) begin
            n_fail++; $display("FAIL reset8: got %h want 0", {b_ready, b_busy, b_start, b_err, b_we, b_addr, b_data});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        n_tests++;
        if ({a_ready, a_busy} !== 2'b00) begin
            n_fail++; $display("FAIL idle_after_reset: got ready/busy %b want 00", {a_ready, a_busy});
        end
    endtask

    task automatic test_load_pe2();
        logic [W:0] word;
        s_valid = 1'b1;
        cycle();
        n_tests++;
        if ({a_ready, a_we} !== {1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL enter_load: got ready %b we %h want 1 0000", a_ready, a_we);
        end
        for (int i = 0; i < 3; i++) begin
            word = rnd_word();
            s_pe = 4'd2; s_data = word; s_last = (i == 2);
            cycle();
            n_tests++;
            if (a_we !== 16'h0004 || a_addr !== 4'(i) || a_data !== word || b_we !== 8'h04) begin
                n_fail++;
                $display("FAIL pe2_write[%0d]: got we %h addr %0d data %h we8 %h want 0004 %0d %h 04",
                         i, a_we, a_addr, a_data, b_we, i, word);
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        n_tests++;
        if ({a_ready, a_busy, a_err} !== 3'b010) begin
            n_fail++; $display("FAIL pe2_done: got ready/busy/err %b want 010", {a_ready, a_busy, a_err});
        end
        cycle();
        n_tests++;
        if (a_we !== 16'h0000 || a_data !== word) begin
            n_fail++; $display("FAIL we_single_cycle: got we %h data %h want 0000 %h", a_we, a_data, word);
        end
    endtask

    task automatic test_go_halt();
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        n_tests++;
        if ({a_busy, a_start} !== 2'b10) begin
            n_fail++; $display("FAIL halt_in_done: got busy/start %b want 10", {a_busy, a_start});
        end
        go = 1'b1;
        cycle();
        go = 1'b0;
        n_tests++;
        if ({a_busy, a_start} !== 2'b01) begin
            n_fail++; $display("FAIL go_start: got busy/start %b want 01", {a_busy, a_start});
        end
        cycle();
        n_tests++;
        if (a_start !== 1'b1) begin
            n_fail++; $display("FAIL start_level: got %b want 1", a_start);
        end
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        n_tests++;
        if ({a_ready, a_busy, a_start} !== 3'b000) begin
            n_fail++; $display("FAIL halt_idle: got ready/busy/start %b want 000", {a_ready, a_busy, a_start});
        end
    endtask

    task automatic test_overflow();
        s_valid = 1'b1;
        cycle();
        for (int i = 0; i < 17; i++) begin
            s_pe = 4'd5; s_data = rnd_word(); s_last = (i == 16);
            cycle();
            n_tests++;
            if (i < 16) begin
                if (a_we !== 16'h0020 || a_addr !== 4'(i) || a_err !== 1'b0) begin
                    n_fail++; $display("FAIL ovf_write[%0d]: got we %h addr %0d err %b want 0020 %0d 0", i, a_we, a_addr, a_err, i);
                end
            end else begin
                if (a_we !== 16'h0000 || a_err !== 1'b1 || b_err !== 1'b1 || a_busy !== 1'b1) begin
                    n_fail++; $display("FAIL ovf_drop: got we %h err %b err8 %b busy %b want 0000 1 1 1", a_we, a_err, b_err, a_busy);
                end
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        go = 1'b1; halt = 1'b1;
        cycle();
        go = 1'b0; halt = 1'b0;
        n_tests++;
        if (a_start !== 1'b1) begin
            n_fail++; $display("FAIL go_wins: got start %b want 1", a_start);
        end
        halt = 1'b1;
        cycle();
        halt = 1'b0;
    endtask

    task automatic test_bad_index();
        s_valid = 1'b1;
        cycle();
        n_tests++;
        if ({a_err, b_err} !== 2'b00) begin
            n_fail++; $display("FAIL err_clear: got err16/err8 %b want 00", {a_err, b_err});
        end
        s_pe = 4'd15; s_data = rnd_word(); s_last = 1'b1;
        cycle();
        s_valid = 1'b0; s_last = 1'b0;
        n_tests++;
        if (b_we !== 8'h00 || b_err !== 1'b1 || a_we !== 16'h8000 || a_err !== 1'b0) begin
            n_fail++; $display("FAIL bad_index: got we8 %h err8 %b we16 %h err16 %b want 00 1 8000 0", b_we, b_err, a_we, a_err);
        end
        go = 1'b1;
        cycle();
        go = 1'b0; halt = 1'b1;
        cycle();
        halt = 1'b0;
        n_tests++;
        if (b_err !== 1'b1 || b_busy !== 1'b0) begin
            n_fail++; $display("FAIL err_sticky: got err8 %b busy %b want 1 0", b_err, b_busy);
        end
    endtask

    task automatic test_reset_mid_load();
        s_valid = 1'b1;
        cycle();
        for (int i = 0; i < 2; i++) begin
            s_pe = 4'd3; s_data = rnd_word(); s_last = 1'b0;
            cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({a_ready, a_busy, a_start, a_err, a_we, a_addr, a_data} !== '0) begin
            n_fail++; $display("FAIL async_reset: got %h want 0", {a_ready, a_busy, a_start, a_err, a_we, a_addr, a_data});
        end
        #1 rst_n = 1'b1;
        cycle();
        n_tests++;
        if ({a_ready, a_we} !== {1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL reload_enter: got ready %b we %h want 1 0000", a_ready, a_we);
        end
        s_last = 1'b1;
        cycle();
        s_valid = 1'b0; s_last = 1'b0;
        n_tests++;
        if (a_we !== 16'h0008 || a_addr !== 4'd0) begin
            n_fail++; $display("FAIL reload_addr: got we %h addr %0d want 0008 0", a_we, a_addr);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_pe    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 5));
            s_data  = rnd_word();
            s_last  = ($urandom_range(0, 31) == 0);
            go      = ($urandom_range(0, 9) < 3);
            halt    = ($urandom_range(0, 9) < 2);
            cycle();
            n_tests++;
            if ({a_ready, a_busy, a_start, a_err, a_we, a_addr, a_data} !==
                {e_ready, e_busy, e_start, e_err[0], e_we[0], e_addr[0], e_data[0]}) begin
                n_fail++;
                $display("FAIL rand16[%0d]: got %h want %h", n,
                         {a_ready, a_busy, a_start, a_err, a_we, a_addr, a_data},
                         {e_ready, e_busy, e_start, e_err[0], e_we[0], e_addr[0], e_data[0]});
            end
            n_tests++;
            if ({b_ready, b_busy, b_start, b_err, b_we, b_addr, b_data} !==
                {e_ready, e_busy, e_start, e_err[1], e_we[1][7:0], e_addr[1], e_data[1]}) begin
                n_fail++;
                $display("FAIL rand8[%0d]: got %h want %h", n,
                         {b_ready, b_busy, b_start, b_err, b_we, b_addr, b_data},
                         {e_ready, e_busy, e_start, e_err[1], e_we[1][7:0], e_addr[1], e_data[1]});
            end
        end
        s_valid = 1'b0; s_last = 1'b0; go = 1'b0; halt = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_pe2();
        test_go_halt();
        test_overflow();
        test_bad_index();
        test_reset_mid_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctx_loader.md
CTX_LOADER -- requirements
Module: ctx_loader

Interface
REQ-001 Parameter: WIDTH, 120, context word is WIDTH+1 bits ([WIDTH:0]).
REQ-002 Parameter: NUM_PE, 16, number of PEs served.
REQ-003 Parameter: DEPTH, 16, context slots per PE.
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 s_valid  in  1  host word valid.
REQ-007 s_ready  out  1  loader accepts word this cycle.
REQ-008 s_data  in  WIDTH+1  context word.
REQ-009 s_pe  in  4  target PE index.
REQ-010 s_last  in  1  final word of the configuration.
REQ-011 go  in  1  begin execution after load.
REQ-012 halt  in  1  stop execution and return to idle.
REQ-013 pe_data  out  WIDTH+1  context word broadcast to all PE context caches.
REQ-014 pe_we  out  NUM_PE  one-hot write strobe, one bit per PE.
REQ-015 pe_addr  out  4  context slot written.
REQ-016 start  out  1  level; high while PEs execute; drives every PE's start.
REQ-017 busy  out  1  high in LOAD or DONE.
REQ-018 err  out  1  sticky overflow or bad-index flag.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DONE, RUN.
REQ-020 IDLE: s_valid high SHALL move to LOAD and clear all per-PE slot counters; this word is not consumed.
REQ-021 s_ready SHALL be high only in LOAD; a word transfers when s_valid and s_ready are both high.
REQ-022 On a transfer, pe_data, pe_addr = slot count of s_pe, and pe_we = one-hot(s_pe) SHALL be registered; they appear the next cycle, giving a latency of 1.
REQ-023 pe_we SHALL be high for exactly one cycle per accepted word and zero otherwise; pe_data holds its last value.
REQ-024 The slot counter of s_pe SHALL increment by 1 on each write; counters are 5 bits and saturate at DEPTH.
REQ-025 A word for a PE whose count equals DEPTH, or with s_pe >= NUM_PE, SHALL be consumed without a write (pe_we stays 0) and SHALL set err.
REQ-026 A transfer with s_last high SHALL move LOAD to DONE, including when that word is dropped per REQ-025.
REQ-027 DONE: go SHALL move to RUN; start rises the cycle after go is sampled.
REQ-028 RUN: start SHALL stay high; halt SHALL move to IDLE with start low the next cycle.
REQ-029 go outside DONE and halt outside RUN SHALL be ignored.
REQ-030 If go and halt are high together in DONE, go SHALL win.
REQ-031 err SHALL clear only on reset or on the IDLE-to-LOAD transition.

Reset
REQ-032 RST_N low SHALL immediately force: state IDLE, s_ready 0, pe_we 0, pe_data 0, pe_addr 0, start 0, busy 0, err 0, all counters 0.
REQ-033 Reset mid-LOAD SHALL abandon the partial load; no pe_we pulse is emitted after RST_N falls.
REQ-034 After RST_N rises, the first edge SHALL evaluate IDLE behaviour normally.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the WIDTH, NUM_PE and DEPTH defaults, shared with the PE context cache.
REQ-036 One sub-module SHALL be natural: ctx_slot_ctr, the per-PE saturating counter bank with clear, increment-by-index and full-detect.
REQ-037 Everything else SHALL be in the top module, with all outputs registered.

Verification
REQ-038 Reset, then 3 words to PE 2 with the last word flagged -> pe_we=0x0004 for 3 cycles, pe_addr 0,1,2, state DONE, err=0.
REQ-039 17 words to PE 5 -> 16 writes at pe_addr 0..15; the 17th is dropped; err=1 next cycle.
REQ-040 Word with s_pe=15 and NUM_PE=8 -> no pe_we pulse; err=1.
REQ-041 In DONE, go pulse -> start=1 one cycle later; halt in RUN -> start=0 next cycle; state IDLE.
REQ-042 go and halt asserted together in DONE -> RUN entered.
REQ-043 RST_N asserted mid-LOAD after 2 writes -> outputs reset asynchronously; new load restarts pe_addr at 0.
